mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter USE_MEM_READY, default 0; 1 = FETCH/MEM_RD/MEM_WR stall until mem_ready, 0 = mem_ready ignored (single-cycle memory).
REQ-002 Parameter ALUCTRL_W, default 4; width of ALUCtrl.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces FETCH and idle outputs immediately.
REQ-005 Instr  in  32  current instruction register contents (opcode [31:26], funct [5:0]).
REQ-006 Zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  in  1  memory completion strobe; used only when USE_MEM_READY=1.
REQ-008 PCWrite, IRWrite, RegWrite, MemWrite, MemRead  out  1 each  one-cycle strobes.
REQ-009 ALUCtrl  out  ALUCTRL_W  0=ADD, 1=SUB, 2=OR, 3=LUI (imm<<16).
REQ-010 ALUSrcA  out  1  0=PC, 1=GPR[rs]; ALUSrcB  out  2  0=GPR[rt], 1=const 4, 2=ext imm, 3=ext imm<<2.
REQ-011 RegDst  out  2  0=rt, 1=rd, 2=$31; MemtoReg  out  2  0=ALUOut, 1=MDR, 2=PC.
REQ-012 ExtOp  out  2  0=zero, 1=sign, 2=upper; PCSrc  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=GPR[rs].
REQ-013 State  out  4  current FSM state encoding, debug only.

Function
REQ-014 States: FETCH, DECODE, EXE_R, EXE_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP.
REQ-015 FETCH: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUCtrl=ADD, PCSrc=0, PCWrite=1; -> DECODE (when USE_MEM_READY=1, strobes and transition only in the cycle mem_ready=1; otherwise remain in FETCH with MemRead=1, all write strobes 0).
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUCtrl=ADD (precompute branch target); no write strobes; next state by opcode/funct.
REQ-017 Decode map: R-type addu/subu -> EXE_R; R-type jr -> JUMP; ori, lui -> EXE_I; lw, sw -> MEM_ADDR; beq -> BRANCH; j, jal -> JUMP; any other opcode or funct -> FETCH with no architectural write.
REQ-018 EXE_R: ALUSrcA=1, ALUSrcB=0, ALUCtrl ADD (addu) / SUB (subu); -> WB_R. WB_R: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-019 EXE_I: ALUSrcA=1, ALUSrcB=2; ori ExtOp=0 ALUCtrl=OR; lui ExtOp=2 ALUCtrl=LUI; -> WB_I. WB_I: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUCtrl=ADD; lw -> MEM_RD, sw -> MEM_WR.
REQ-021 MEM_RD: MemRead=1; -> WB_MEM (stall rule as REQ-015). WB_MEM: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-022 MEM_WR: MemWrite=1 held until completion; -> FETCH (stall rule as REQ-015; MemWrite asserted every stall cycle, memory commits once on mem_ready).
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUCtrl=SUB, PCSrc=1, PCWrite=Zero; -> FETCH.
REQ-024 JUMP: PCWrite=1; j/jal PCSrc=2, jr PCSrc=3; jal additionally RegWrite=1, RegDst=2, MemtoReg=2 (PC already PC+4); -> FETCH.
REQ-025 Latency with USE_MEM_READY=0: R/ori/lui 4 cycles, lw 5, sw 4, beq/j/jal/jr 3; each memory stall cycle adds exactly 1.
REQ-026 Outputs are Moore (decoded from State and Instr), except PCWrite in BRANCH and stall gating on mem_ready; all unlisted strobes 0, unlisted selects 0.
REQ-027 At most one of RegWrite/MemWrite asserted in any cycle.

Reset
REQ-028 reset=1 drives State=FETCH and all write strobes 0 asynchronously; asserted mid-instruction, no further strobe of that instruction is issued.
REQ-029 First rising edge after reset deassertion performs FETCH behaviour.

Structure
REQ-030 State encodings, opcode/funct constants and ALUCtrl/select encodings live in a shared package/include used also by the datapath.
REQ-031 One sub-module, mc_decode (combinational opcode/funct -> instruction class), instantiated inside mc_ctrl.

Verification
REQ-032 addu (funct 0x21), USE_MEM_READY=0 -> States FETCH,DECODE,EXE_R,WB_R; RegWrite=1 only in cycle 4 with RegDst=1.
REQ-033 lw, USE_MEM_READY=1, mem_ready low 2 cycles in FETCH and MEM_RD -> 9 cycles total, RegWrite=1 once with MemtoReg=1.
REQ-034 beq with Zero=1 -> PCWrite=1, PCSrc=1 in cycle 3; Zero=0 -> PCWrite=0; both return to FETCH.
REQ-035 jal -> cycle 3 PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2.
REQ-036 opcode 0x3F -> DECODE then FETCH, no RegWrite/MemWrite/branch PCWrite.
REQ-037 reset pulsed during MEM_WR -> MemWrite drops in same cycle, State=FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller and its datapath:
// FSM states, opcode/funct values, ALU operations and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXE_R    = 4'd2,
        ST_EXE_I    = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_WB_I     = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        IC_BAD  = 4'd0,
        IC_ADDU = 4'd1,
        IC_SUBU = 4'd2,
        IC_JR   = 4'd3,
        IC_ORI  = 4'd4,
        IC_LUI  = 4'd5,
        IC_LW   = 4'd6,
        IC_SW   = 4'd7,
        IC_BEQ  = 4'd8,
        IC_J    = 4'd9,
        IC_JAL  = 4'd10
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_OR  = 2;
    localparam int ALU_LUI = 3;

    localparam logic       SRCA_PC   = 1'b0;
    localparam logic       SRCA_RS   = 1'b1;
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_IMM4 = 2'd3;

    localparam logic [1:0] DST_RT    = 2'd0;
    localparam logic [1:0] DST_RD    = 2'd1;
    localparam logic [1:0] DST_RA    = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] iclass
);

    always_comb begin
        iclass = IC_BAD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: iclass = IC_ADDU;
                    FN_SUBU: iclass = IC_SUBU;
                    FN_JR:   iclass = IC_JR;
                    default: iclass = IC_BAD;
                endcase
            end
            OP_ORI:  iclass = IC_ORI;
            OP_LUI:  iclass = IC_LUI;
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            OP_BEQ:  iclass = IC_BEQ;
            OP_J:    iclass = IC_J;
            OP_JAL:  iclass = IC_JAL;
            default: iclass = IC_BAD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM. Moore outputs decoded from State and
// Instr; optional stall on mem_ready for FETCH, MEM_RD and MEM_WR.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int USE_MEM_READY = 0,
    parameter int ALUCTRL_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 MemRead,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic [1:0]           ExtOp,
    output logic [1:0]           PCSrc,
    output logic [3:0]           State
);

    state_t     state_q, state_d;
    logic [3:0] iclass_raw;
    iclass_t    ic;
    logic       stall;
    logic       unused_instr;

    mc_decode u_decode (
        .opcode (Instr[31:26]),
        .funct  (Instr[5:0]),
        .iclass (iclass_raw)
    );

    assign ic           = iclass_t'(iclass_raw);
    assign stall        = (USE_MEM_READY != 0) && !mem_ready;
    assign unused_instr = ^Instr[25:6];
    assign State        = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        ALUCtrl  = ALUCTRL_W'(ALU_ADD);
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_RT;
        RegDst   = DST_RT;
        MemtoReg = WB_ALU;
        ExtOp    = EXT_ZERO;
        PCSrc    = PC_ALU;

        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (!stall) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM4;
                ExtOp   = EXT_SIGN;
                case (ic)
                    IC_ADDU, IC_SUBU:   state_d = ST_EXE_R;
                    IC_ORI, IC_LUI:     state_d = ST_EXE_I;
                    IC_LW, IC_SW:       state_d = ST_MEM_ADDR;
                    IC_BEQ:             state_d = ST_BRANCH;
                    IC_J, IC_JAL, IC_JR: state_d = ST_JUMP;
                    default:            state_d = ST_FETCH;
                endcase
            end
            ST_EXE_R: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = SRCB_RT;
                ALUCtrl = (ic == IC_SUBU) ? ALUCTRL_W'(ALU_SUB) : ALUCTRL_W'(ALU_ADD);
                state_d = ST_WB_R;
            end
            ST_WB_R: begin
                RegDst   = DST_RD;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_EXE_I: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = SRCB_IMM;
                if (ic == IC_LUI) begin
                    ExtOp   = EXT_UPPER;
                    ALUCtrl = ALUCTRL_W'(ALU_LUI);
                end else begin
                    ExtOp   = EXT_ZERO;
                    ALUCtrl = ALUCTRL_W'(ALU_OR);
                end
                state_d = ST_WB_I;
            end
            ST_WB_I: begin
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = SRCB_IMM;
                ExtOp   = EXT_SIGN;
                state_d = (ic == IC_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                MemRead = 1'b1;
                if (!stall) state_d = ST_WB_MEM;
            end
            ST_WB_MEM: begin
                MemtoReg = WB_MDR;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEM_WR: begin
                // Held through stalls; the memory commits on the mem_ready cycle.
                MemWrite = 1'b1;
                if (!stall) state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = SRCB_RT;
                ALUCtrl = ALUCTRL_W'(ALU_SUB);
                PCSrc   = PC_ALUOUT;
                PCWrite = Zero;
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = (ic == IC_JR) ? PC_RS : PC_JUMP;
                if (ic == IC_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = DST_RA;
                    MemtoReg = WB_PC;
                end
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset must silence strobes immediately, not only after the flop updates.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction vector table fed through a scoreboard
// queue, plus a hand-written reset-during-store sequence.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        sel;

    logic       d0_PCWrite, d0_IRWrite, d0_RegWrite, d0_MemWrite, d0_MemRead, d0_ALUSrcA;
    logic [3:0] d0_ALUCtrl, d0_State;
    logic [1:0] d0_ALUSrcB, d0_RegDst, d0_MemtoReg, d0_ExtOp, d0_PCSrc;
    logic       d1_PCWrite, d1_IRWrite, d1_RegWrite, d1_MemWrite, d1_MemRead, d1_ALUSrcA;
    logic [3:0] d1_ALUCtrl, d1_State;
    logic [1:0] d1_ALUSrcB, d1_RegDst, d1_MemtoReg, d1_ExtOp, d1_PCSrc;

    logic       o_PCWrite, o_IRWrite, o_RegWrite, o_MemWrite, o_MemRead, o_ALUSrcA;
    logic [3:0] o_ALUCtrl, o_State;
    logic [1:0] o_ALUSrcB, o_RegDst, o_MemtoReg, o_ExtOp, o_PCSrc;

    mc_ctrl #(.USE_MEM_READY(0), .ALUCTRL_W(4)) dut0 (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(d0_PCWrite), .IRWrite(d0_IRWrite), .RegWrite(d0_RegWrite),
        .MemWrite(d0_MemWrite), .MemRead(d0_MemRead), .ALUCtrl(d0_ALUCtrl),
        .ALUSrcA(d0_ALUSrcA), .ALUSrcB(d0_ALUSrcB), .RegDst(d0_RegDst),
        .MemtoReg(d0_MemtoReg), .ExtOp(d0_ExtOp), .PCSrc(d0_PCSrc), .State(d0_State)
    );

    mc_ctrl #(.USE_MEM_READY(1), .ALUCTRL_W(4)) dut1 (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(d1_PCWrite), .IRWrite(d1_IRWrite), .RegWrite(d1_RegWrite),
        .MemWrite(d1_MemWrite), .MemRead(d1_MemRead), .ALUCtrl(d1_ALUCtrl),
        .ALUSrcA(d1_ALUSrcA), .ALUSrcB(d1_ALUSrcB), .RegDst(d1_RegDst),
        .MemtoReg(d1_MemtoReg), .ExtOp(d1_ExtOp), .PCSrc(d1_PCSrc), .State(d1_State)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel) begin
            o_PCWrite = d1_PCWrite; o_IRWrite = d1_IRWrite; o_RegWrite = d1_RegWrite;
            o_MemWrite = d1_MemWrite; o_MemRead = d1_MemRead; o_ALUSrcA = d1_ALUSrcA;
            o_ALUCtrl = d1_ALUCtrl; o_State = d1_State; o_ALUSrcB = d1_ALUSrcB;
            o_RegDst = d1_RegDst; o_MemtoReg = d1_MemtoReg; o_ExtOp = d1_ExtOp; o_PCSrc = d1_PCSrc;
        end else begin
            o_PCWrite = d0_PCWrite; o_IRWrite = d0_IRWrite; o_RegWrite = d0_RegWrite;
            o_MemWrite = d0_MemWrite; o_MemRead = d0_MemRead; o_ALUSrcA = d0_ALUSrcA;
            o_ALUCtrl = d0_ALUCtrl; o_State = d0_State; o_ALUSrcB = d0_ALUSrcB;
            o_RegDst = d0_RegDst; o_MemtoReg = d0_MemtoReg; o_ExtOp = d0_ExtOp; o_PCSrc = d0_PCSrc;
        end
    end

    // trace packs one State nibble per cycle, oldest first.
    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        sel;
        int          sf;
        int          sm;
        int          cyc;
        logic [63:0] trace;
        int          irw;
        int          mrd;
        int          regw;
        int          memw;
        int          pcw;
        logic [1:0]  pcsrc;
        logic [1:0]  rd;
        logic [1:0]  m2r;
        logic [3:0]  alu3;
        logic [1:0]  ext3;
        logic        a3;
        logic [1:0]  b3;
    } vec_t;

    vec_t tbl[16];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        vec_t        e;
        logic [63:0] trace = '0;
        int          cyc = 0, irw = 0, mrd = 0, regw = 0, memw = 0, pcw = 0, fc = 0, mc = 0;
        logic [1:0]  pcsrc = '0, rd = '0, m2r = '0, ext3 = '0, b3 = '0;
        logic [3:0]  alu3 = '0;
        logic        a3 = 1'b0, left = 1'b0, done = 1'b0;

        reset = 1'b1; Instr = v.instr; Zero = v.zero; sel = v.sel; mem_ready = 1'b1;
        #1 reset = 1'b0;
        exp_q.push_back(v);
        for (int k = 0; k < 30 && !done; k++) begin
            if (k > 0) @(negedge clk);
            if (left && o_State == ST_FETCH) begin
                done = 1'b1;
            end else begin
                if (o_State == ST_FETCH && fc < v.sf) begin
                    mem_ready = 1'b0; fc++;
                end else if ((o_State == ST_MEM_RD || o_State == ST_MEM_WR) && mc < v.sm) begin
                    mem_ready = 1'b0; mc++;
                end else begin
                    mem_ready = 1'b1;
                end
                #1;
                cyc++;
                trace = {trace[59:0], o_State};
                if (o_State != ST_FETCH) left = 1'b1;
                irw  += int'(o_IRWrite);
                mrd  += int'(o_MemRead);
                regw += int'(o_RegWrite);
                memw += int'(o_MemWrite);
                if (o_State != ST_FETCH) pcw += int'(o_PCWrite);
                if (o_RegWrite) begin rd = o_RegDst; m2r = o_MemtoReg; end
                if (cyc == 3) begin alu3 = o_ALUCtrl; ext3 = o_ExtOp; a3 = o_ALUSrcA; b3 = o_ALUSrcB; end
                pcsrc = o_PCSrc;
                check($sformatf("v%0d_excl", idx), 64'(o_RegWrite & o_MemWrite), 64'd0);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: got no return to FETCH expected return within 30 cycles", idx);
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d_cyc", idx),   64'(cyc),  64'(e.cyc));
        check($sformatf("v%0d_trace", idx), trace,     e.trace);
        check($sformatf("v%0d_irw", idx),   64'(irw),  64'(e.irw));
        check($sformatf("v%0d_mrd", idx),   64'(mrd),  64'(e.mrd));
        check($sformatf("v%0d_regw", idx),  64'(regw), 64'(e.regw));
        check($sformatf("v%0d_memw", idx),  64'(memw), 64'(e.memw));
        check($sformatf("v%0d_pcw", idx),   64'(pcw),  64'(e.pcw));
        check($sformatf("v%0d_pcsrc", idx), 64'(pcsrc), 64'(e.pcsrc));
        check($sformatf("v%0d_regdst", idx), 64'(rd),  64'(e.rd));
        check($sformatf("v%0d_m2r", idx),   64'(m2r),  64'(e.m2r));
        check($sformatf("v%0d_alu3", idx),  64'(alu3), 64'(e.alu3));
        check($sformatf("v%0d_ext3", idx),  64'(ext3), 64'(e.ext3));
        check($sformatf("v%0d_srca3", idx), 64'(a3),   64'(e.a3));
        check($sformatf("v%0d_srcb3", idx), 64'(b3),   64'(e.b3));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        //           instr        z  sel sf sm cyc trace           irw mrd rw mw pcw pcs rd m2r alu ext a  b
        tbl[0]  = '{32'h00851021, 0, 0, 0, 0, 4, 64'h0127,       1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        tbl[1]  = '{32'h00851023, 0, 0, 0, 0, 4, 64'h0127,       1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0};
        tbl[2]  = '{32'h344200FF, 0, 0, 0, 0, 4, 64'h0138,       1, 1, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2};
        tbl[3]  = '{32'h3C021234, 0, 0, 0, 0, 4, 64'h0138,       1, 1, 1, 0, 0, 0, 0, 0, 3, 2, 1, 2};
        tbl[4]  = '{32'h8C820004, 0, 0, 0, 0, 5, 64'h01459,      1, 2, 1, 0, 0, 0, 0, 1, 0, 1, 1, 2};
        tbl[5]  = '{32'hAC820008, 0, 0, 0, 0, 4, 64'h0146,       1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2};
        tbl[6]  = '{32'h10850003, 1, 0, 0, 0, 3, 64'h01A,        1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0};
        tbl[7]  = '{32'h10850003, 0, 0, 0, 0, 3, 64'h01A,        1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0};
        tbl[8]  = '{32'h08000010, 0, 0, 0, 0, 3, 64'h01B,        1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{32'h0C000010, 0, 0, 0, 0, 3, 64'h01B,        1, 1, 1, 0, 1, 2, 2, 2, 0, 0, 0, 0};
        tbl[10] = '{32'h03E00008, 0, 0, 0, 0, 3, 64'h01B,        1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{32'hFC000000, 1, 0, 0, 0, 2, 64'h01,         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{32'h00000000, 1, 0, 0, 0, 2, 64'h01,         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{32'h8C820004, 0, 1, 2, 2, 9, 64'h000145559,  1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[14] = '{32'hAC820008, 0, 1, 0, 3, 7, 64'h0146666,    1, 1, 0, 4, 0, 0, 0, 0, 0, 1, 1, 2};
        tbl[15] = '{32'h00851021, 0, 1, 0, 0, 4, 64'h0127,       1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

        reset = 1'b1; Instr = '0; Zero = 1'b0; mem_ready = 1'b1; sel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state0", 64'(d0_State), 64'(ST_FETCH));
        check("rst_state1", 64'(d1_State), 64'(ST_FETCH));
        check("rst_strobes0", 64'({d0_PCWrite, d0_IRWrite, d0_RegWrite, d0_MemWrite, d0_MemRead}), 64'd0);
        check("rst_strobes1", 64'({d1_PCWrite, d1_IRWrite, d1_RegWrite, d1_MemWrite, d1_MemRead}), 64'd0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) run(tbl[i], i);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted while a store is in MEM_WR.
        reset = 1'b1; Instr = 32'hAC820008; sel = 1'b0; mem_ready = 1'b1;
        #1 reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (d0_State == ST_MEM_WR) found = 1'b1;
        end
        check("mw_reach", 64'(found), 64'd1);
        check("mw_pre", 64'(d0_MemWrite), 64'd1);
        reset = 1'b1;
        #1;
        check("mw_drop", 64'(d0_MemWrite), 64'd0);
        check("mw_state", 64'(d0_State), 64'(ST_FETCH));
        check("mw_memrd", 64'(d0_MemRead), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_fetch", 64'({d0_MemRead, d0_IRWrite, d0_PCWrite}), 64'h7);
        @(posedge clk);
        #1;
        check("post_rst_decode", 64'(d0_State), 64'(ST_DECODE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
